// File: rtl/gt_streamer.sv
// rtl/gt_streamer.sv - Streams garbled-table rows from a DPRAM as W-bit words.
// Each row takes one FETCH, one LOAD and K/W SEND beats; the address is preloaded so it is valid throughout FETCH.
module gt_streamer #(
  parameter int S = 20,
  parameter int K = 128,
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [S-1:0] num_gates,
  output logic [S-1:0] gt_rd_addr,
  input  logic [K-1:0] gt_rd_data,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic         done
);

  localparam int NW  = K / W;
  localparam int WCW = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [WCW-1:0] LAST_WORD = WCW'(NW - 1);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, SEND, FIN} state_t;

  state_t         state;
  logic [S-1:0]   ngates;
  logic [S:0]     row_cnt;
  logic [S:0]     row_next;
  logic [WCW-1:0] word_cnt;
  logic [K-1:0]   shreg;

  // One extra row-counter bit keeps 2*num_gates representable for the largest num_gates.
  assign row_next = row_cnt + (S+1)'(1);
  assign out_data = shreg[W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ngates     <= '0;
      row_cnt    <= '0;
      word_cnt   <= '0;
      shreg      <= '0;
      gt_rd_addr <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ngates  <= num_gates;
            row_cnt <= '0;
            busy    <= 1'b1;
            if (num_gates == '0) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state      <= FETCH;
              gt_rd_addr <= '0;
            end
          end
        end
        FETCH: begin
          state <= LOAD;
        end
        LOAD: begin
          shreg     <= gt_rd_data;
          word_cnt  <= '0;
          out_valid <= 1'b1;
          state     <= SEND;
        end
        SEND: begin
          if (out_ready) begin
            shreg    <= shreg >> W;
            word_cnt <= word_cnt + WCW'(1);
            if (word_cnt == LAST_WORD) begin
              out_valid <= 1'b0;
              row_cnt   <= row_next;
              if (row_next == {ngates, 1'b0}) begin
                state <= FIN;
                done  <= 1'b1;
              end else begin
                state      <= FETCH;
                gt_rd_addr <= row_next[S-1:0];
              end
            end
          end
        end
        FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gt_streamer.sv
// tb/tb_gt_streamer.sv - Self-checking bench for gt_streamer against a row/word reference model.
module tb_gt_streamer;
  localparam int S  = 8;
  localparam int K  = 128;
  localparam int W  = 32;
  localparam int NW = K / W;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [S-1:0] num_gates = '0;
  logic [S-1:0] gt_rd_addr;
  logic [K-1:0] gt_rd_data = '0;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic         busy;
  logic         done;

  gt_streamer #(.S(S), .K(K), .W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .num_gates(num_gates),
    .gt_rd_addr(gt_rd_addr), .gt_rd_data(gt_rd_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  initial forever #5 clk = ~clk;

  logic [K-1:0] mem [0:255];
  always @(posedge clk) gt_rd_data <= mem[gt_rd_addr];

  int n_cmp = 0;
  int n_fail = 0;
  logic [W-1:0] got [$];
  int done_cnt = 0;
  int stall_err = 0;
  bit rand_ready = 1'b0;

  initial forever begin
    @(posedge clk);
    #1;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Observes the stream at the falling edge: transfers, stall stability, done pulses.
  initial begin
    bit           prev_stall;
    logic [W-1:0] prev_data;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && (!out_valid || out_data !== prev_data)) stall_err++;
        if (out_valid && out_ready) got.push_back(out_data);
        if (done) done_cnt++;
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
      end
    end
  end

  function automatic logic [W-1:0] exp_word(int idx);
    logic [K-1:0] row_v;
    row_v = mem[(idx / NW) % 256];
    return row_v[(idx % NW)*W +: W];
  endfunction

  task automatic fill_random();
    for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic pulse_start(input int ng);
    @(posedge clk);
    #1;
    start = 1'b1;
    num_gates = S'(ng);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget, output bit ok, output int words_at);
    ok = 1'b0;
    words_at = -1;
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        words_at = got.size();
      end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp += 5;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    if (out_data !== '0) begin n_fail++; $display("FAIL reset_data got %h want 0", out_data); end
    if (gt_rd_addr !== '0) begin n_fail++; $display("FAIL reset_addr got %h want 0", gt_rd_addr); end
  endtask

  task automatic test_basic();
    int base, d0, lat, wat;
    bit ok;
    for (int r = 0; r < 256; r++)
      mem[r] = {32'(4*r+3), 32'(4*r+2), 32'(4*r+1), 32'(4*r)};
    rand_ready = 1'b0;
    base = got.size();
    d0 = done_cnt;
    pulse_start(1);
    lat = 0;
    for (int c = 1; c <= 10 && lat == 0; c++) begin
      @(negedge clk);
      if (out_valid) lat = c;
    end
    n_cmp++;
    if (lat !== 3) begin n_fail++; $display("FAIL basic_latency got %0d want 3", lat); end
    wait_done(d0, 50, ok, wat);
    n_cmp += 4;
    if (!ok) begin n_fail++; $display("FAIL basic_timeout got no done want done"); end
    if (got.size() - base !== 8) begin n_fail++; $display("FAIL basic_count got %0d want 8", got.size() - base); end
    if (wat - base !== 8) begin n_fail++; $display("FAIL basic_done_pos got %0d want 8", wat - base); end
    if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL basic_done_cnt got %0d want 1", done_cnt - d0); end
    for (int i = 0; i < 8 && base + i < got.size(); i++) begin
      n_cmp++;
      if (got[base+i] !== 32'(i)) begin n_fail++; $display("FAIL basic_word%0d got %h want %h", i, got[base+i], 32'(i)); end
    end
  endtask

  task automatic test_zero();
    int base, d0;
    base = got.size();
    d0 = done_cnt;
    pulse_start(0);
    @(negedge clk);
    n_cmp += 2;
    if (done !== 1'b1) begin n_fail++; $display("FAIL zero_done got %b want 1", done); end
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL zero_valid got %b want 0", out_valid); end
    @(negedge clk);
    n_cmp += 2;
    if (done !== 1'b0) begin n_fail++; $display("FAIL zero_done_len got %b want 0", done); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy got %b want 0", busy); end
    repeat (3) @(negedge clk);
    n_cmp += 2;
    if (got.size() !== base) begin n_fail++; $display("FAIL zero_words got %0d want 0", got.size() - base); end
    if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL zero_done_cnt got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_random_ready();
    int base, d0, s0, wat;
    bit ok;
    fill_random();
    rand_ready = 1'b1;
    base = got.size();
    d0 = done_cnt;
    s0 = stall_err;
    pulse_start(3);
    wait_done(d0, 400, ok, wat);
    rand_ready = 1'b0;
    n_cmp += 5;
    if (!ok) begin n_fail++; $display("FAIL rand_timeout got no done want done"); end
    if (got.size() - base !== 24) begin n_fail++; $display("FAIL rand_count got %0d want 24", got.size() - base); end
    if (stall_err - s0 !== 0) begin n_fail++; $display("FAIL rand_stall got %0d unstable want 0", stall_err - s0); end
    if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL rand_done_cnt got %0d want 1", done_cnt - d0); end
    if (gt_rd_addr !== 8'd5) begin n_fail++; $display("FAIL rand_last_addr got %0d want 5", gt_rd_addr); end
    for (int i = 0; i < 24 && base + i < got.size(); i++) begin
      n_cmp++;
      if (got[base+i] !== exp_word(i)) begin n_fail++; $display("FAIL rand_word%0d got %h want %h", i, got[base+i], exp_word(i)); end
    end
  endtask

  task automatic test_restart_ignored();
    int base, d0, wat;
    bit ok;
    fill_random();
    base = got.size();
    d0 = done_cnt;
    pulse_start(2);
    for (int c = 0; c < 10 && !out_valid; c++) @(negedge clk);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    start = 1'b1;
    num_gates = 8'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(d0, 200, ok, wat);
    repeat (10) @(negedge clk);
    n_cmp += 4;
    if (!ok) begin n_fail++; $display("FAIL restart_timeout got no done want done"); end
    if (got.size() - base !== 16) begin n_fail++; $display("FAIL restart_count got %0d want 16", got.size() - base); end
    if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL restart_done_cnt got %0d want 1", done_cnt - d0); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL restart_busy got %b want 0", busy); end
    for (int i = 0; i < 16 && base + i < got.size(); i++) begin
      n_cmp++;
      if (got[base+i] !== exp_word(i)) begin n_fail++; $display("FAIL restart_word%0d got %h want %h", i, got[base+i], exp_word(i)); end
    end
  endtask

  task automatic test_abort();
    int base, d0, wat;
    bit ok, hit;
    logic [K-1:0] row1;
    fill_random();
    row1 = mem[1];
    d0 = done_cnt;
    pulse_start(2);
    hit = 1'b0;
    for (int c = 0; c < 60 && !hit; c++) begin
      @(negedge clk);
      if (out_valid && out_data === row1[2*W +: W]) hit = 1'b1;
    end
    n_cmp++;
    if (!hit) begin n_fail++; $display("FAIL abort_reach got no row1 word2 want reached"); end
    #1;
    rst = 1'b1;
    #1;
    n_cmp += 3;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid got %b want 0", out_valid); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", busy); end
    if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done got %b want 0", done); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (done_cnt !== d0) begin n_fail++; $display("FAIL abort_no_done got %0d pulses want 0", done_cnt - d0); end
    base = got.size();
    d0 = done_cnt;
    pulse_start(1);
    wait_done(d0, 60, ok, wat);
    n_cmp += 2;
    if (!ok) begin n_fail++; $display("FAIL abort_restart_timeout got no done want done"); end
    if (got.size() - base !== 8) begin n_fail++; $display("FAIL abort_restart_count got %0d want 8", got.size() - base); end
    for (int i = 0; i < 8 && base + i < got.size(); i++) begin
      n_cmp++;
      if (got[base+i] !== exp_word(i)) begin n_fail++; $display("FAIL abort_word%0d got %h want %h", i, got[base+i], exp_word(i)); end
    end
  endtask

  task automatic test_max();
    int base, d0, wat;
    bit ok;
    fill_random();
    base = got.size();
    d0 = done_cnt;
    pulse_start(255);
    wait_done(d0, 4000, ok, wat);
    n_cmp += 4;
    if (!ok) begin n_fail++; $display("FAIL max_timeout got no done want done"); end
    if (got.size() - base !== 2040) begin n_fail++; $display("FAIL max_count got %0d want 2040", got.size() - base); end
    if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL max_done_cnt got %0d want 1", done_cnt - d0); end
    if (gt_rd_addr !== 8'd253) begin n_fail++; $display("FAIL max_last_addr got %0d want 253", gt_rd_addr); end
    for (int i = 0; i < 2040 && base + i < got.size(); i++) begin
      n_cmp++;
      if (got[base+i] !== exp_word(i)) begin n_fail++; $display("FAIL max_word%0d got %h want %h", i, got[base+i], exp_word(i)); end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    test_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_basic();
    test_zero();
    test_random_ready();
    test_restart_ignored();
    test_abort();
    test_max();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/gt_streamer.md
GT_STREAMER -- requirements
Module: gt_streamer

Interface
REQ-001 Parameter S, default 20, address/gate-index width; matches gate-id width of garbling engine.
REQ-002 Parameter K, default 128, label / garbled-table row width.
REQ-003 Parameter W, default 32, output word width; K SHALL be an integer multiple of W.
REQ-004 clk  in  1  clock; all state changes on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 start  in  1  one-cycle request to begin streaming; sampled only in IDLE.
REQ-007 num_gates  in  S  number of garbled gates to stream; sampled with start.
REQ-008 gt_rd_addr  out  S  read address into garbled-table DPRAM port 0.
REQ-009 gt_rd_data  in  K  DPRAM read data; valid the cycle after gt_rd_addr is presented.
REQ-010 out_data  out  W  stream word.
REQ-011 out_valid  out  1  out_data valid.
REQ-012 out_ready  in  1  consumer accepts; transfer occurs on edge where out_valid & out_ready.
REQ-013 busy  out  1  high in any state other than IDLE.
REQ-014 done  out  1  one-cycle pulse on stream completion.

Function
REQ-015 Stream order: rows GT[0], GT[1], ..., GT[2*num_gates-1] (row 2g = t0, row 2g+1 = t1 of gate g); each row emitted as K/W words, least-significant word first.
REQ-016 FSM states: IDLE, FETCH, LOAD, SEND, FIN.
REQ-017 IDLE: start=1 -> latch num_gates, clear row counter; num_gates=0 -> FIN, else -> FETCH. start=0 -> stay.
REQ-018 FETCH: drive gt_rd_addr = row counter (low S bits); -> LOAD unconditionally.
REQ-019 LOAD: capture gt_rd_data into K-bit shift register, clear word counter; -> SEND.
REQ-020 SEND: out_valid=1, out_data = shift register [W-1:0]; on transfer, shift right by W and increment word counter.
REQ-021 SEND, transfer of word K/W-1: increment row counter; if new row counter = 2*num_gates -> FIN, else -> FETCH.
REQ-022 FIN: done=1 for exactly one cycle; -> IDLE.
REQ-023 Row counter SHALL be S+1 bits so 2*num_gates never wraps; num_gates up to 2^S-1 supported; gt_rd_addr wraps modulo 2^S (caller guarantees memory depth).
REQ-024 Latency: start accepted at edge n -> FETCH cycle n+1, LOAD n+2, first out_valid in cycle n+3.
REQ-025 While out_valid=1 and out_ready=0, out_data and out_valid SHALL hold stable; no word dropped or duplicated.
REQ-026 out_valid SHALL be 0 in all states except SEND; out_valid SHALL not depend combinationally on out_ready.
REQ-027 start asserted while busy SHALL be ignored; num_gates changes while busy SHALL have no effect.
REQ-028 gt_rd_addr SHALL hold its last value outside FETCH (no spurious reads required, value otherwise don't-care but deterministic).
REQ-029 Steady-state cost per row with out_ready=1: K/W + 2 cycles.

Reset
REQ-030 On rst: state IDLE, out_valid=0, done=0, busy=0, out_data=0, gt_rd_addr=0, counters and shift register cleared.
REQ-031 rst asserted mid-stream SHALL abort immediately; no done pulse; after release, block accepts a new start normally.

Verification
REQ-032 K=128,W=32,S=8; num_gates=1, GT[0]=0x0003_0002_0001_0000 pattern (words 0..3), GT[1]=words 4..7, out_ready=1 -> out_data 0,1,2,3,4,5,6,7; first valid 3 cycles after start; done pulse once after word 7.
REQ-033 num_gates=0, start -> no out_valid, done high in cycle after start, busy low afterwards.
REQ-034 num_gates=3, out_ready random 50% -> 24 words, exact order per REQ-015, each word stable while stalled, memory addresses 0..5 read once each.
REQ-035 start pulsed again during SEND of num_gates=2 run -> ignored; exactly 16 words and one done.
REQ-036 rst asserted during SEND of row 1 word 2 -> out_valid=0, busy=0 next cycle, no done; new start with num_gates=1 streams 8 words from row 0.
REQ-037 num_gates=2^S-1 (255) -> row counter reaches 510 without wrap, 2040 words, single done.
